decrypt_scheduler: RTL and testbench

Message-level scheduler for the three-lane decryption datapath. Accepts a ciphertext byte stream, latches the algorithm selection at the start of each message, routes every byte of that message to the matching decryptor lane, and drives the output mux select. It holds off new input until the selected decryptor has drained its plaintext through the registered output mux. It sits between the input interface and the decryptor bank + output mux.

---
 rtl/decrypt_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_decrypt_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_scheduler.sv
// Purpose : message-level scheduler routing a ciphertext byte stream to one of three decryptor lanes.
// Latency : an accepted byte appears on its lane one cycle later; mux select is registered alongside.
// Backpr. : ready_o drops from the cycle after TERM_CHAR (or truncation) until the lane drains + 1 flush cycle.
module decrypt_scheduler #(
  parameter int                 D_WIDTH   = 8,
  parameter logic [D_WIDTH-1:0] TERM_CHAR = 8'hFA,
  parameter int                 MAX_LEN   = 50,
  parameter int                 TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_select_i,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               busy0_i,
  input  logic               busy1_i,
  input  logic               busy2_i,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  output logic [1:0]         mux_select_o,
  output logic               busy_o,
  output logic               err_o
);

  // Scheduler states; DISCARD swallows a message whose selection was invalid.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STREAM  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;

  localparam logic [1:0] SEL_INVALID = 2'd3;
  localparam logic [7:0] MAX_LEN_C   = 8'(MAX_LEN);
  localparam logic [7:0] TMO_LAST_C  = 8'(TIMEOUT - 1);

  logic [2:0]              state_q, state_d;
  logic [1:0]              active_sel_q, active_sel_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic [7:0]              byte_cnt_q, byte_cnt_d;
  logic [7:0]              tmo_cnt_q, tmo_cnt_d;
  logic                    err_q, err_d;
  logic [2:0]              lane_vld_q, lane_vld_d;
  logic [2:0][D_WIDTH-1:0] lane_dat_q, lane_dat_d;

  logic                    fwd;
  logic [1:0]              fwd_sel;
  logic                    sel_busy;
  logic                    is_term;
  logic [7:0]              cnt_inc;

  // Only the lane owning the current message may influence draining.
  always_comb begin
    sel_busy = 1'b0;
    case (active_sel_q)
      2'd0:    sel_busy = busy0_i;
      2'd1:    sel_busy = busy1_i;
      2'd2:    sel_busy = busy2_i;
      default: sel_busy = 1'b0;
    endcase
  end

  assign ready_o = (state_q == S_IDLE) || (state_q == S_STREAM) || (state_q == S_DISCARD);
  assign busy_o  = (state_q != S_IDLE);
  assign is_term = (data_i == TERM_CHAR);
  // Byte counter saturates so a stuck stream can never wrap it back below MAX_LEN.
  assign cnt_inc = (byte_cnt_q >= MAX_LEN_C) ? MAX_LEN_C : byte_cnt_q + 8'd1;

  // Next-state, forwarding decision and error aggregation.
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    mux_sel_d    = mux_sel_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    fwd          = 1'b0;
    fwd_sel      = active_sel_q;
    // A byte offered while not ready is lost; every error source ORs into one pulse.
    err_d        = valid_i && !ready_o;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          active_sel_d = cfg_select_i;
          byte_cnt_d   = 8'd1;
          if (cfg_select_i == SEL_INVALID) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end else begin
            fwd       = 1'b1;
            fwd_sel   = cfg_select_i;
            mux_sel_d = cfg_select_i;
            if (is_term) begin
              state_d   = S_WAIT;
              tmo_cnt_d = 8'd0;
            end else begin
              state_d = S_STREAM;
            end
          end
        end
      end

      S_STREAM: begin
        if (valid_i) begin
          fwd        = 1'b1;
          byte_cnt_d = cnt_inc;
          if (is_term) begin
            state_d   = S_WAIT;
            tmo_cnt_d = 8'd0;
          end else if (cnt_inc == MAX_LEN_C) begin
            // Truncated message: the lane never sees TERM_CHAR for it.
            err_d     = 1'b1;
            state_d   = S_WAIT;
            tmo_cnt_d = 8'd0;
          end
        end
      end

      S_WAIT: begin
        if (sel_busy) begin
          state_d = S_DRAIN;
        end else if (tmo_cnt_q == TMO_LAST_C) begin
          err_d   = 1'b1;
          state_d = S_FLUSH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      S_DRAIN: begin
        if (!sel_busy) state_d = S_FLUSH;
      end

      // One extra cycle so the last plaintext byte clears the registered output mux.
      S_FLUSH: state_d = S_IDLE;

      S_DISCARD: begin
        if (valid_i && is_term) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane strobe/data: only the forwarded lane carries the byte, others stay zero.
  always_comb begin
    lane_vld_d = '0;
    lane_dat_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (fwd && (fwd_sel == 2'(i))) begin
        lane_vld_d[i] = 1'b1;
        lane_dat_d[i] = data_i;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      active_sel_q <= 2'd0;
      mux_sel_q    <= 2'd0;
      byte_cnt_q   <= 8'd0;
      tmo_cnt_q    <= 8'd0;
      err_q        <= 1'b0;
      lane_vld_q   <= '0;
      lane_dat_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      mux_sel_q    <= mux_sel_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
      lane_vld_q   <= lane_vld_d;
      lane_dat_q   <= lane_dat_d;
    end
  end

  assign data0_o      = lane_dat_q[0];
  assign data1_o      = lane_dat_q[1];
  assign data2_o      = lane_dat_q[2];
  assign valid0_o     = lane_vld_q[0];
  assign valid1_o     = lane_vld_q[1];
  assign valid2_o     = lane_vld_q[2];
  assign mux_select_o = mux_sel_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_decrypt_scheduler.sv
// Purpose : directed bench for decrypt_scheduler with a lane-strobe scoreboard.
// Latency : expected strobes carry the cycle they must appear in (accept cycle + 1).
// Backpr. : directed waits only; a watchdog bounds the whole run.
module tb_decrypt_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_select_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       busy0_i, busy1_i, busy2_i;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o;
  logic [1:0] mux_select_o;
  logic       busy_o;
  logic       err_o;

  decrypt_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_select_i(cfg_select_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .busy0_i(busy0_i), .busy1_i(busy1_i), .busy2_i(busy2_i),
    .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
    .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o),
    .mux_select_o(mux_select_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         lane;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   err_seen  = 0;
  int   exp_err   = 0;

  logic [2:0]      vld_w;
  logic [2:0][7:0] dat_w;
  assign vld_w = {valid2_o, valid1_o, valid0_o};
  assign dat_w = {data2_o, data1_o, data0_o};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for one cycle; lane < 0 means no strobe is expected.
  task automatic send(input logic [1:0] sel, input logic [7:0] b, input int lane);
    exp_t e;
    cfg_select_i = sel;
    data_i       = b;
    valid_i      = 1'b1;
    if (lane >= 0) begin
      e.lane = lane;
      e.dat  = b;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    tick();
    valid_i = 1'b0;
  endtask

  // Monitor: every lane strobe is popped against the scoreboard; idle lanes must be zero.
  always @(negedge clk) begin
    if (err_o) err_seen++;
    for (int l = 0; l < 3; l++) begin
      if (vld_w[l]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: lane %0d data %0h at cycle %0d, none required", l, dat_w[l], cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.lane != l || e.dat !== dat_w[l] || e.cyc != cyc) begin
            errors++;
            $display("FAIL strobe: got lane %0d data %0h cycle %0d, required lane %0d data %0h cycle %0d",
                     l, dat_w[l], cyc, e.lane, e.dat, e.cyc);
          end
        end
        for (int m = 0; m < 3; m++) begin
          if (m != l) begin
            checks++;
            if (vld_w[m] !== 1'b0 || dat_w[m] !== 8'h00) begin
              errors++;
              $display("FAIL idle_lane: lane %0d valid %0b data %0h while lane %0d active, required 0/00",
                       m, vld_w[m], dat_w[m], l);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_select_i = 2'd0; data_i = 8'h00; valid_i = 1'b0;
    busy0_i = 1'b0; busy1_i = 1'b0; busy2_i = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_mux", mux_select_o, 0);
    check("rst_valids", {valid2_o, valid1_o, valid0_o}, 0);
    check("rst_data", {data2_o, data1_o, data0_o}, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: lane 1 message, then a 5-cycle busy burst
    send(2'd1, 8'h41, 1);
    send(2'd1, 8'h42, 1);
    send(2'd1, 8'hFA, 1);
    check("t1_ready_after_term", ready_o, 0);
    check("t1_busy_o", busy_o, 1);
    check("t1_mux", mux_select_o, 1);
    busy1_i = 1'b1;
    repeat (5) tick();
    busy1_i = 1'b0;
    check("t1_ready_drain", ready_o, 0);
    tick();
    check("t1_ready_flush", ready_o, 0);
    check("t1_busy_flush", busy_o, 1);
    tick();
    check("t1_ready_idle", ready_o, 1);
    check("t1_mux_hold_idle", mux_select_o, 1);
    check("t1_err_count", err_seen, exp_err);

    // Test 2: invalid select is discarded, then a lane 0 message
    send(2'd3, 8'h58, -1);
    exp_err++;
    send(2'd3, 8'hFA, -1);
    check("t2_idle_ready", ready_o, 1);
    check("t2_idle_busy", busy_o, 0);
    send(2'd0, 8'h43, 0);
    check("t2_mux", mux_select_o, 0);
    send(2'd0, 8'hFA, 0);
    busy0_i = 1'b1;
    tick();
    busy0_i = 1'b0;
    tick();
    tick();
    check("t2_ready_idle", ready_o, 1);
    check("t2_err_count", err_seen, exp_err);

    // Test 3: lane 2 never busy -> timeout after 16 WAIT_BUSY cycles; busy1 is noise
    send(2'd2, 8'hFA, 2);
    busy1_i = 1'b1;
    repeat (15) tick();
    check("t3_wait_busy_o", busy_o, 1);
    check("t3_no_err_yet", err_o, 0);
    check("t3_ready_wait", ready_o, 0);
    tick();
    busy1_i = 1'b0;
    exp_err++;
    check("t3_timeout_err", err_o, 1);
    check("t3_flush_ready", ready_o, 0);
    check("t3_flush_busy", busy_o, 1);
    tick();
    check("t3_idle_ready", ready_o, 1);
    check("t3_err_single", err_o, 0);

    // Test 4: 50 non-TERM bytes truncate the message; a 51st byte is refused
    for (int i = 0; i < 50; i++) send(2'd0, 8'h20 + 8'(i), 0);
    exp_err++;
    check("t4_trunc_err", err_o, 1);
    check("t4_ready_wait", ready_o, 0);
    check("t4_busy_o", busy_o, 1);
    tick();
    check("t4_err_gap", err_o, 0);
    send(2'd0, 8'h77, -1);
    exp_err++;
    check("t4_drop_err", err_o, 1);
    check("t4_still_wait", ready_o, 0);
    busy0_i = 1'b1;
    tick();
    busy0_i = 1'b0;
    tick();
    tick();
    check("t4_ready_idle", ready_o, 1);

    // Test 5: mid-message select change and foreign busy are ignored; then reset
    send(2'd0, 8'h50, 0);
    cfg_select_i = 2'd2;
    busy2_i = 1'b1;
    send(2'd2, 8'h51, 0);
    send(2'd2, 8'h52, 0);
    check("t5_ready_stream", ready_o, 1);
    check("t5_mux", mux_select_o, 0);
    rst_n = 1'b0; data_i = 8'h53; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("t5_rst_valids", {valid2_o, valid1_o, valid0_o}, 0);
    check("t5_rst_data", {data2_o, data1_o, data0_o}, 0);
    check("t5_rst_mux", mux_select_o, 0);
    check("t5_rst_err", err_o, 0);
    check("t5_rst_ready", ready_o, 1);
    check("t5_rst_busy", busy_o, 0);
    rst_n = 1'b1;
    busy2_i = 1'b0;
    repeat (3) tick();

    check("final_sb_empty", sb_q.size(), 0);
    check("final_err_count", err_seen, exp_err);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
